// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller between the pipeline and a cache port.
//
// Takes one memory operation at a time from the execute stage. It checks the
// operation for legality and alignment, issues a word-aligned request with byte
// strobes, and waits for the cache to complete it. Load data is returned aligned
// and sign- or zero-extended. An operation that stays in REQ+WAIT for too long
// is aborted.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   valid_i                memory op present in the stage
//   mem_rw_i               1 = store, 0 = load
//   funct3_i               access size/sign (inst[14:12])
//   addr_i, wdata_i        byte address, store data (rs2)
//   stall_o                hold the pipeline
//   rdata_o                aligned/extended load data (valid in DONE, held after)
//   misalign_o             one-cycle pulse: illegal or misaligned access
//   err_o                  one-cycle pulse (in DONE): operation aborted on timeout
//   req_valid_o/req_ready_i, req_we_o, req_addr_o, req_wdata_o, req_wstrb_o
//                          cache request channel
//   resp_valid_i, resp_rdata_i   cache completion and read word
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_rw_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wstrb_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i
);

  // The counter is at least 8 bits wide, and wider if TIMEOUT_CYC needs it.
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_f3_ok;
  logic          w_aligned;
  logic          w_legal;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata_lane;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;
  logic          w_timeout;

  // Decode the legality of the incoming operation.
  always_comb begin
    w_f3_ok   = 1'b0;
    w_aligned = 1'b1;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~mem_rw_i;  // unsigned forms exist only for loads
      default:                w_f3_ok = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b01:   w_aligned = ~addr_i[0];
      2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_legal = w_f3_ok & w_aligned;

  // Place the store data on its lanes. The data is replicated, so the strobes
  // alone pick which bytes get written.
  always_comb begin
    w_wstrb      = 4'b1111;
    w_wdata_lane = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_wstrb      = 4'b0001 << addr_i[1:0];
        w_wdata_lane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_wstrb      = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata_lane = {2{wdata_i[15:0]}};
      end
      default: begin
        w_wstrb      = 4'b1111;
        w_wdata_lane = wdata_i;
      end
    endcase
    if (!mem_rw_i) begin
      w_wstrb = 4'b0000;
    end
  end

  // Shift the addressed byte/half down to bit 0, then extend it.
  assign w_shifted = resp_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // r_cnt is 0 in the first REQ cycle. It hits CNT_LAST in the
  // TIMEOUT_CYC-th cycle spent in REQ+WAIT.
  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
          if (w_legal) begin
            w_state_next = ST_REQ;
            stall_o      = 1'b1;
          end else begin
            misalign_o   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        // If the handshake comes in the last allowed cycle, there is no cycle
        // left for a response, so the timeout wins.
        if (w_timeout) begin
          w_state_next = ST_DONE;
        end else if (req_ready_i) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (resp_valid_i || w_timeout) begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_i && w_legal) begin
            r_addr   <= {addr_i[31:2], 2'b00};
            r_off    <= addr_i[1:0];
            r_funct3 <= funct3_i;
            r_we     <= mem_rw_i;
            r_wdata  <= w_wdata_lane;
            r_wstrb  <= w_wstrb;
            r_cnt    <= '0;
          end
        end
        ST_REQ, ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == ST_WAIT && resp_valid_i) begin
            r_rdata <= w_load_data;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign req_valid_o = (r_state == ST_REQ);
  assign req_we_o    = r_we;
  assign req_addr_o  = r_addr;
  assign req_wdata_o = r_wdata;
  assign req_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- randomized self-checking bench for lsu_ctrl (TIMEOUT_CYC = 4).
// The reference model works from the access rules: which ops are legal, which
// bytes an access covers, and how many cycles an op may spend before it times out.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        mem_rw_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        err_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wstrb_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rdata;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_rw_i(mem_rw_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .rdata_o(rdata_o), .misalign_o(misalign_o), .err_o(err_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
    .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input logic rw, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (rw && f3[2]) return 1'b0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_strb(input logic rw, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    int off = int'(a[1:0]);
    if (rw) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + acc_size(f3)) s[i] = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r = 32'd0;
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) begin
      r = r | (((d >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v = w >> (8 * int'(a[1:0]));
    if (acc_size(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (acc_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One whole transaction. The caller must be in an IDLE cycle, at least 1 ns after the edge.
  // d_ready: REQ cycles before ready is raised. d_resp: WAIT cycles before the response.
  task automatic do_op(input string name, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int d_ready, input int d_resp, input logic [31:0] rword);
    bit legal;
    bit in_wait;
    bit ok;
    int c;
    int w;
    logic [31:0] exp_rd;
    valid_i = 1'b1; mem_rw_i = rw; funct3_i = f3; addr_i = a; wdata_i = d;
    req_ready_i = 1'b0; resp_valid_i = 1'b0;
    #1;
    legal = ref_legal(rw, f3, a);
    if (!legal) begin
      check({name, " misalign"}, {31'd0, misalign_o}, 32'd1);
      check({name, " stall_ill"}, {31'd0, stall_o}, 32'd0);
      check({name, " reqv_ill"}, {31'd0, req_valid_o}, 32'd0);
      tick();
      valid_i = 1'b0;
      #1;
      check({name, " misalign_drop"}, {31'd0, misalign_o}, 32'd0);
      check({name, " reqv_after_ill"}, {31'd0, req_valid_o}, 32'd0);
      check({name, " rdata_hold"}, rdata_o, last_rdata);
      $display("op %-10s rw=%0d f3=%0d addr=%h -> rejected", name, rw, f3, a);
      return;
    end
    check({name, " stall_acc"}, {31'd0, stall_o}, 32'd1);
    check({name, " misalign0"}, {31'd0, misalign_o}, 32'd0);
    tick();
    c = 0; w = 0; in_wait = 0; ok = 0;
    while (1) begin
      // Drive unrelated values on the inputs the DUT should not be sampling now.
      valid_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
      if (!in_wait) begin
        req_ready_i = (c == d_ready); resp_valid_i = 1'($urandom); resp_rdata_i = $urandom;
      end else begin
        req_ready_i = 1'($urandom); resp_valid_i = (w == d_resp);
        resp_rdata_i = (w == d_resp) ? rword : $urandom;
      end
      #1;
      check({name, " stall_busy"}, {31'd0, stall_o}, 32'd1);
      check({name, " reqv"}, {31'd0, req_valid_o}, {31'd0, !in_wait});
      check({name, " err_busy"}, {31'd0, err_o}, 32'd0);
      if (!in_wait) begin
        check({name, " req_addr"}, req_addr_o, a & 32'hFFFF_FFFC);
        check({name, " req_we"}, {31'd0, req_we_o}, {31'd0, rw});
        check({name, " req_wstrb"}, {28'd0, req_wstrb_o}, {28'd0, ref_strb(rw, f3, a)});
        if (rw) check({name, " req_wdata"}, req_wdata_o, ref_wdata(f3, d));
      end
      if (in_wait && w == d_resp) begin
        ok = 1; break;
      end else if (c == TO - 1) begin
        ok = 0; break;
      end else if (!in_wait && c == d_ready) begin
        in_wait = 1;
      end else if (in_wait) begin
        w++;
      end
      c++;
      tick();
    end
    tick();
    // DONE cycle: a new valid op here must be ignored.
    valid_i = 1'b1; mem_rw_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0;
    req_ready_i = 1'b1; resp_valid_i = 1'b1; resp_rdata_i = $urandom;
    #1;
    exp_rd = ok ? ref_load(f3, a, rword) : 32'd0;
    if (rw && ok) exp_rd = ref_load(f3, a, rword);
    check({name, " rdata_done"}, rdata_o, exp_rd);
    check({name, " err_done"}, {31'd0, err_o}, {31'd0, !ok});
    check({name, " stall_done"}, {31'd0, stall_o}, 32'd0);
    check({name, " reqv_done"}, {31'd0, req_valid_o}, 32'd0);
    last_rdata = exp_rd;
    tick();
    valid_i = 1'b0; resp_valid_i = 1'b0; req_ready_i = 1'b0;
    #1;
    check({name, " reqv_idle"}, {31'd0, req_valid_o}, 32'd0);
    check({name, " stall_idle"}, {31'd0, stall_o}, 32'd0);
    check({name, " err_idle"}, {31'd0, err_o}, 32'd0);
    check({name, " rdata_idle"}, rdata_o, last_rdata);
    $display("op %-10s rw=%0d f3=%0d addr=%h rdy=%0d rsp=%0d -> %s rdata=%h",
             name, rw, f3, a, d_ready, d_resp, ok ? "done" : "timeout", exp_rd);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; mem_rw_i = 1'b0; funct3_i = 3'b000; addr_i = 32'd0;
    wdata_i = 32'd0; req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_rdata_i = 32'd0;
    last_rdata = 32'd0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst stall", {31'd0, stall_o}, 32'd0);
    check("rst reqv", {31'd0, req_valid_o}, 32'd0);
    check("rst err", {31'd0, err_o}, 32'd0);
    check("rst misalign", {31'd0, misalign_o}, 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    check("rst we", {31'd0, req_we_o}, 32'd0);
    check("rst addr", req_addr_o, 32'd0);
    check("rst wdata", req_wdata_o, 32'd0);
    check("rst wstrb", {28'd0, req_wstrb_o}, 32'd0);

    do_op("lw_basic", 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    do_op("lb_neg", 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
    do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
    do_op("sh_hi", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 0, 32'h0);
    do_op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    do_op("timeout", 1'b0, 3'b010, 32'h40, 32'h0, 100, 0, 32'h0);

    // Reset while in WAIT. The late response after it must not be taken.
    valid_i = 1'b1; mem_rw_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    #1;
    tick();
    valid_i = 1'b0; req_ready_i = 1'b1;
    #1;
    tick();
    req_ready_i = 1'b0; rst_i = 1'b1;
    #1;
    check("wait stall", {31'd0, stall_o}, 32'd1);
    tick();
    rst_i = 1'b0; resp_valid_i = 1'b1; resp_rdata_i = 32'h5555_AAAA;
    #1;
    check("rstw stall", {31'd0, stall_o}, 32'd0);
    check("rstw reqv", {31'd0, req_valid_o}, 32'd0);
    check("rstw rdata", rdata_o, 32'd0);
    tick();
    resp_valid_i = 1'b0;
    #1;
    check("rstw no_done", rdata_o, 32'd0);
    check("rstw err", {31'd0, err_o}, 32'd0);
    last_rdata = 32'd0;
    $display("op reset_wait -> abandoned");

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      ra = $urandom & 32'h0000_FFFF;
      do_op("rand", 1'($urandom), 3'($urandom), ra, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
